// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage hazard controller: forwarding selects, load-use stall, saturating stall counter.
// Define PIPE_HAZARD_FWD_EN for forwarding; otherwise dependents stall until the producer reaches WB.

module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_id_valid,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_use_rs,
  input  logic             i_id_use_rt,
  input  logic             i_id_wreg,
  input  logic             i_id_m2reg,
  input  logic [4:0]       i_id_rn,
  output logic             o_stall,
  output logic [1:0]       o_fwda,
  output logic [1:0]       o_fwdb,
  output logic [CNT_W-1:0] o_stall_cnt
);

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic [4:0] rn;
  } slot_t;

  slot_t            r_ex;
  slot_t            r_mem;
  slot_t            r_wb;
  logic [CNT_W-1:0] r_stall_cnt;

  logic       w_ex_a;
  logic       w_ex_b;
  logic       w_mem_a;
  logic       w_mem_b;
  logic       w_stall;
  logic [1:0] w_fwda;
  logic [1:0] w_fwdb;
  logic       w_unused;

  function automatic logic f_match(input logic use_src, input logic [4:0] src, input slot_t s);
    return use_src & s.wreg & (s.rn == src) & (src != 5'd0);
  endfunction

  assign w_ex_a  = f_match(i_id_use_rs, i_id_rs, r_ex);
  assign w_ex_b  = f_match(i_id_use_rt, i_id_rt, r_ex);
  assign w_mem_a = f_match(i_id_use_rs, i_id_rs, r_mem);
  assign w_mem_b = f_match(i_id_use_rt, i_id_rt, r_mem);

`ifdef PIPE_HAZARD_FWD_EN
  // A load in EX has no data yet, so it falls through to the MEM check and raises stall.
  always_comb begin
    w_stall = i_id_valid & (w_ex_a | w_ex_b) & r_ex.m2reg;
    w_fwda  = 2'b00;
    w_fwdb  = 2'b00;
    if (w_ex_a && !r_ex.m2reg) w_fwda = 2'b01;
    else if (w_mem_a)          w_fwda = r_mem.m2reg ? 2'b11 : 2'b10;
    if (w_ex_b && !r_ex.m2reg) w_fwdb = 2'b01;
    else if (w_mem_b)          w_fwdb = r_mem.m2reg ? 2'b11 : 2'b10;
  end

  // WB slot never forwards: the register file writes before it is read.
  assign w_unused = ^r_wb;
`else
  always_comb begin
    w_stall = i_id_valid & (w_ex_a | w_ex_b | w_mem_a | w_mem_b);
    w_fwda  = 2'b00;
    w_fwdb  = 2'b00;
  end

  assign w_unused = ^{r_wb, r_mem.m2reg};
`endif

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      if (i_id_valid && !w_stall) r_ex <= {i_id_wreg, i_id_m2reg, i_id_rn};
      else                        r_ex <= '0;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_stall     = w_stall;
  assign o_fwda      = w_fwda;
  assign o_fwdb      = w_fwdb;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed literal cases plus randomized traffic
// checked every cycle against an instruction-history model; a CNT_W=2 copy checks saturation.

module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        id_valid, id_use_rs, id_use_rt, id_wreg, id_m2reg;
  logic [4:0]  id_rs, id_rt, id_rn;
  logic        stall, s_stall;
  logic [1:0]  fwda, fwdb, s_fwda, s_fwdb;
  logic [15:0] stall_cnt;
  logic [1:0]  s_cnt;
  int          total = 0;
  int          bad = 0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(16)) u_dut (
    .i_clk(clk), .i_clr(clr), .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt), .i_id_wreg(id_wreg), .i_id_m2reg(id_m2reg),
    .i_id_rn(id_rn), .o_stall(stall), .o_fwda(fwda), .o_fwdb(fwdb), .o_stall_cnt(stall_cnt));

  pipe_hazard_ctrl #(.CNT_W(2)) u_sat (
    .i_clk(clk), .i_clr(clr), .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt), .i_id_wreg(id_wreg), .i_id_m2reg(id_m2reg),
    .i_id_rn(id_rn), .o_stall(s_stall), .o_fwda(s_fwda), .o_fwdb(s_fwdb), .o_stall_cnt(s_cnt));

  // Model: hist[k] is the instruction that left ID k+1 edges ago (bubble = no write).
  typedef struct {
    bit wr;
    bit ld;
    int rn;
  } rec_t;

  rec_t hist[3];
  int   n_stalls = 0;

  function automatic bit writes(rec_t r, bit use_f, int src);
    return use_f && r.wr && (r.rn == src) && (src != 0);
  endfunction

  function automatic void model(output bit st, output int fa, output int fb);
    bit u[2];
    int s[2];
    int sel[2];
    bit hz;
    bit done;
    u  = '{id_use_rs, id_use_rt};
    s  = '{int'(id_rs), int'(id_rt)};
    hz = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sel[k] = 0;
      done   = 1'b0;
      for (int age = 0; age < 2; age++) begin
        if (!done && writes(hist[age], u[k], s[k])) begin
          if (!FWD) begin
            hz   = 1'b1;
            done = 1'b1;
          end else if (age == 0 && hist[0].ld) begin
            hz = 1'b1;
          end else begin
            sel[k] = (age == 0) ? 1 : (hist[1].ld ? 3 : 2);
            done   = 1'b1;
          end
        end
      end
    end
    st = id_valid && hz;
    fa = sel[0];
    fb = sel[1];
  endfunction

  always @(posedge clk or posedge clr) begin
    bit st;
    int fa, fb;
    if (clr) begin
      for (int i = 0; i < 3; i++) hist[i] = '{wr: 1'b0, ld: 1'b0, rn: 0};
      n_stalls = 0;
    end else begin
      model(st, fa, fb);
      hist[2] = hist[1];
      hist[1] = hist[0];
      if (id_valid && !st) hist[0] = '{wr: id_wreg, ld: id_m2reg, rn: int'(id_rn)};
      else                 hist[0] = '{wr: 1'b0, ld: 1'b0, rn: 0};
      if (st) n_stalls++;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit st;
    int fa, fb;
    if (chk_en && !clr) begin
      model(st, fa, fb);
      check("model_stall", int'(stall), int'(st));
      check("model_fwda", int'(fwda), fa);
      check("model_fwdb", int'(fwdb), fb);
      check("model_cnt", int'(stall_cnt), (n_stalls > 65535) ? 65535 : n_stalls);
      check("model_sat_cnt", int'(s_cnt), (n_stalls > 3) ? 3 : n_stalls);
      check("model_sat_stall", int'(s_stall), int'(st));
    end
  end

  task automatic issue(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                       input bit wr, input bit ld, input int rn);
    id_valid  = v;
    id_rs     = rs[4:0];
    id_use_rs = urs;
    id_rt     = rt[4:0];
    id_use_rt = urt;
    id_wreg   = wr;
    id_m2reg  = ld;
    id_rn     = rn[4:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_sat[5] = '{1, 2, 3, 3, 3};

  initial begin
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    #1 clr = 1'b1;
    #1;
    check("reset_stall", int'(stall), 0);
    check("reset_fwda", int'(fwda), 0);
    check("reset_cnt", int'(stall_cnt), 0);
    tick();
    clr    = 1'b0;
    chk_en = 1'b1;

`ifdef PIPE_HAZARD_FWD_EN
    issue(1, 0, 0, 0, 0, 1, 0, 3);             // add r3
    tick();
    issue(1, 3, 1, 0, 0, 1, 0, 8);             // reads r3 as rs
    #1;
    check("alu_fwda_ex", int'(fwda), 1);
    check("alu_no_stall", int'(stall), 0);
    tick();
    issue(1, 0, 0, 3, 1, 1, 0, 9);             // reads r3 as rt
    #1;
    check("alu_fwdb_mem", int'(fwdb), 2);
    tick();
    issue(1, 0, 0, 0, 0, 1, 1, 4);             // lw r4
    tick();
    issue(1, 4, 1, 0, 0, 1, 0, 10);            // reads r4
    #1;
    check("lu_stall", int'(stall), 1);
    check("lu_cnt0", int'(stall_cnt), 0);
    tick();
    #1;
    check("lu_stall_done", int'(stall), 0);
    check("lu_fwda_load", int'(fwda), 3);
    check("lu_cnt1", int'(stall_cnt), 1);
    tick();
`else
    issue(1, 0, 0, 0, 0, 1, 0, 7);             // add r7
    tick();
    issue(1, 7, 1, 0, 0, 1, 0, 14);            // reads r7
    #1;
    check("nf_stall1", int'(stall), 1);
    check("nf_fwda1", int'(fwda), 0);
    tick();
    #1;
    check("nf_stall2", int'(stall), 1);
    check("nf_fwda2", int'(fwda), 0);
    tick();
    #1;
    check("nf_stall_done", int'(stall), 0);
    check("nf_cnt2", int'(stall_cnt), 2);
    tick();
    issue(1, 0, 0, 0, 0, 1, 0, 9);             // add r9
    tick();
    issue(1, 0, 0, 0, 0, 0, 0, 0);             // unrelated
    tick();
    issue(1, 0, 0, 9, 1, 1, 0, 15);            // reads r9 as rt
    #1;
    check("nf_gap_stall", int'(stall), 1);
    tick();
    #1;
    check("nf_gap_done", int'(stall), 0);
    check("nf_cnt3", int'(stall_cnt), 3);
    tick();
`endif

    issue(1, 0, 0, 0, 0, 1, 1, 0);             // load into r0
    tick();
    issue(1, 0, 1, 0, 1, 1, 0, 11);            // reads r0 twice
    #1;
    check("r0_fwda", int'(fwda), 0);
    check("r0_fwdb", int'(fwdb), 0);
    check("r0_stall", int'(stall), 0);
    tick();

    issue(1, 0, 0, 0, 0, 1, 1, 6);             // lw r6
    tick();
    issue(1, 6, 1, 0, 0, 1, 0, 12);            // reads r6
    #1;
    check("rst_pre_stall", int'(stall), 1);
    clr = 1'b1;
    #1;
    check("rst_async_stall", int'(stall), 0);
    check("rst_async_fwda", int'(fwda), 0);
    check("rst_async_cnt", int'(stall_cnt), 0);
    check("rst_async_sat", int'(s_cnt), 0);
    tick();
    clr = 1'b0;
    issue(1, 5, 1, 5, 1, 1, 0, 13);            // first instruction after reset reads r5
    #1;
    check("post_rst_fwda", int'(fwda), 0);
    check("post_rst_fwdb", int'(fwdb), 0);
    check("post_rst_stall", int'(stall), 0);
    tick();

    for (int i = 0; i < 5; i++) begin
      issue(1, 0, 0, 0, 0, 1, 1, 20);          // lw r20
      tick();
      if (!FWD) begin
        issue(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
      end
      issue(1, 20, 1, 0, 0, 0, 0, 0);          // reader: exactly one stall cycle
      tick();
      #1;
      check("sat_cnt", int'(s_cnt), exp_sat[i]);
      check("wide_cnt", int'(stall_cnt), i + 1);
      tick();
    end

    for (int c = 0; c < 3000; c++) begin
      if (!(stall && $urandom_range(3) != 0)) begin
        issue($urandom_range(7) != 0, $urandom_range(3), $urandom_range(1), $urandom_range(3),
              $urandom_range(1), $urandom_range(1), $urandom_range(2) == 0, $urandom_range(3));
      end
      if ($urandom_range(199) == 0) begin
        clr = 1'b1;
        #2;
        clr = 1'b0;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
